// File: rtl/mopa_seq_pkg.sv
// Shared constants for the MOPA sequencer: ALU opcodes and controller state encodings.
package mopa_seq_pkg;

    localparam logic [3:0] ALU_NOP  = 4'h0;
    localparam logic [3:0] ALU_ADD  = 4'h1;
    localparam logic [3:0] ALU_SUB  = 4'h2;
    localparam logic [3:0] ALU_MUL  = 4'h3;
    localparam logic [3:0] ALU_MOPA = 4'h8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int TILE_W = 128;
    localparam int VEC_W  = 32;

endpackage

// File: rtl/mopa_seq.sv
// MOPA sequencer: streams K vector pairs through the external ALU and owns the
// 4x4x8 accumulator tile for the duration of one outer-product-accumulate run.
module mopa_seq
    import mopa_seq_pkg::*;
#(
    parameter int K_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [K_W-1:0]      k_len,
    input  logic                use_init,
    input  logic [TILE_W-1:0]   init_tile,
    input  logic                vec_valid,
    input  logic [VEC_W-1:0]    vec_a,
    input  logic [VEC_W-1:0]    vec_b,
    output logic                vec_ready,
    output logic [3:0]          alu_ctrl,
    output logic [VEC_W-1:0]    alu_op_a,
    output logic [VEC_W-1:0]    alu_op_b,
    output logic [TILE_W-1:0]   alu_op_matrix,
    input  logic [TILE_W-1:0]   alu_matrix_i,
    output logic                busy,
    output logic                done,
    output logic [TILE_W-1:0]   tile_o
);

    logic [1:0]        state_q, state_d;
    logic [TILE_W-1:0] acc_q, acc_d;
    logic [K_W-1:0]    cnt_q, cnt_d;
    logic              run;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d   = use_init ? init_tile : '0;
                    cnt_d   = k_len;
                    state_d = (k_len != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                // vec_ready is constant in RUN, so vec_valid alone marks an accept
                if (vec_valid) begin
                    acc_d = alu_matrix_i;
                    cnt_d = cnt_q - K_W'(1);
                    if (cnt_q == K_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // ALU operands are zeroed outside RUN so the ALU sees a quiet bus when idle
    assign run           = (state_q == ST_RUN);
    assign vec_ready     = run;
    assign alu_ctrl      = run ? ALU_MOPA : ALU_NOP;
    assign alu_op_a      = run ? vec_a : '0;
    assign alu_op_b      = run ? vec_b : '0;
    assign alu_op_matrix = run ? acc_q : '0;
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign tile_o        = acc_q;

endmodule

// File: tb/tb_mopa_seq.sv
// Directed bench for mopa_seq with a behavioural outer-product ALU on its ALU ports.
module tb_mopa_seq;
    import mopa_seq_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   k_len;
    logic         use_init;
    logic [127:0] init_tile;
    logic         vec_valid;
    logic [31:0]  vec_a, vec_b;
    logic         vec_ready;
    logic [3:0]   alu_ctrl;
    logic [31:0]  alu_op_a, alu_op_b;
    logic [127:0] alu_op_matrix;
    logic [127:0] alu_matrix_i;
    logic         busy, done;
    logic [127:0] tile_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mopa_seq #(.K_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .use_init(use_init),
        .init_tile(init_tile), .vec_valid(vec_valid), .vec_a(vec_a), .vec_b(vec_b),
        .vec_ready(vec_ready), .alu_ctrl(alu_ctrl), .alu_op_a(alu_op_a),
        .alu_op_b(alu_op_b), .alu_op_matrix(alu_op_matrix), .alu_matrix_i(alu_matrix_i),
        .busy(busy), .done(done), .tile_o(tile_o)
    );

    // Reference ALU: element (i,j) += a_i * b_j, wrapping at 8 bits
    always_comb begin
        alu_matrix_i = alu_op_matrix;
        if (alu_ctrl == ALU_MOPA) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    alu_matrix_i[i*32+j*8 +: 8] = alu_op_matrix[i*32+j*8 +: 8]
                        + 8'(alu_op_a[i*8 +: 8] * alu_op_b[j*8 +: 8]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        string        nm;
        logic         ui;
        logic [127:0] init;
        logic [3:0]   k;
        logic [31:0]  a;
        logic [31:0]  b;
        logic [127:0] exp_t;
    } vec_t;

    vec_t vecs[7];

    task automatic do_seq(input vec_t v);
        int c, busy_n, rdy_n;
        @(negedge clk);
        start = 1'b1; use_init = v.ui; init_tile = v.init; k_len = v.k;
        vec_valid = 1'b1; vec_a = v.a; vec_b = v.b;
        @(posedge clk); #1;
        start = 1'b0;
        c = 1; busy_n = 0; rdy_n = 0;
        while (!done && c < 40) begin
            if (busy) busy_n++;
            if (vec_ready) begin
                rdy_n++;
                if (rdy_n == 1) begin
                    chk({v.nm, "_ctrl"}, 128'(alu_ctrl), 128'(ALU_MOPA));
                    chk({v.nm, "_opa"}, 128'(alu_op_a), 128'(v.a));
                    chk({v.nm, "_opb"}, 128'(alu_op_b), 128'(v.b));
                end
            end
            @(posedge clk); #1;
            c++;
        end
        if (busy) busy_n++;
        chk({v.nm, "_done_lat"}, 128'(c), 128'(int'(v.k) + 1));
        chk({v.nm, "_busy_cycles"}, 128'(busy_n), 128'(int'(v.k) + 1));
        chk({v.nm, "_ready_cycles"}, 128'(rdy_n), 128'(v.k));
        chk({v.nm, "_tile"}, tile_o, v.exp_t);
        chk({v.nm, "_ctrl_done"}, 128'(alu_ctrl), 128'(0));
        vec_valid = 1'b0;
        @(posedge clk); #1;
        chk({v.nm, "_idle_busy"}, 128'(busy), 128'(0));
        chk({v.nm, "_idle_done"}, 128'(done), 128'(0));
        chk({v.nm, "_tile_hold"}, tile_o, v.exp_t);
    endtask

    initial begin
        vecs[0] = '{"basic", 1'b0, 128'h0, 4'd1, 32'h04030201, 32'h01010101,
                    128'h04040404_03030303_02020202_01010101};
        vecs[1] = '{"zero_seed", 1'b0, 128'h0, 4'd3, 32'h02020202, 32'h03030303,
                    {16{8'h12}}};
        vecs[2] = '{"wrap_init", 1'b1, {16{8'hFF}}, 4'd1, 32'h01010101, 32'h01010101,
                    128'h0};
        vecs[3] = '{"wrap_prod", 1'b0, 128'h0, 4'd1, 32'h10101010, 32'h10101010,
                    128'h0};
        vecs[4] = '{"zero_len", 1'b1, 128'h0123456789ABCDEF0123456789ABCDEF, 4'd0,
                    32'h01010101, 32'h01010101, 128'h0123456789ABCDEF0123456789ABCDEF};
        vecs[5] = '{"max_len", 1'b0, 128'h0, 4'd15, 32'h01010101, 32'h01010101,
                    {16{8'h0F}}};
        vecs[6] = '{"init_k2", 1'b1, {16{8'h05}}, 4'd2, 32'h01020304, 32'h01010101,
                    128'h07070707_09090909_0B0B0B0B_0D0D0D0D};

        rst = 1'b1; start = 1'b0; k_len = '0; use_init = 1'b0; init_tile = '0;
        vec_valid = 1'b0; vec_a = '0; vec_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 128'(vec_ready), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_ctrl", 128'(alu_ctrl), 128'(0));
        chk("rst_ops", {alu_op_a, alu_op_b, 64'h0} | alu_op_matrix, 128'h0);
        chk("rst_tile", tile_o, 128'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int n = 0; n < 7; n++) begin
            do_seq(vecs[n]);
        end

        // bubbles: three accepts separated by two idle-valid cycles
        @(negedge clk);
        start = 1'b1; use_init = 1'b0; k_len = 4'd3; vec_valid = 1'b0;
        vec_a = 32'h01010101; vec_b = 32'h01010101;
        @(posedge clk); #1;
        start = 1'b0;
        for (int p = 0; p < 3; p++) begin
            for (int q = 0; q < 2; q++) begin
                chk("bub_busy", 128'(busy), 128'(1));
                chk("bub_done", 128'(done), 128'(0));
                @(posedge clk); #1;
            end
            vec_valid = 1'b1;
            @(posedge clk); #1;
            vec_valid = 1'b0;
            if (p < 2) chk("bub_done_early", 128'(done), 128'(0));
            if (p == 0) chk("bub_opm", alu_op_matrix, {16{8'h01}});
        end
        chk("bub_done_final", 128'(done), 128'(1));
        chk("bub_tile", tile_o, {16{8'h03}});
        @(posedge clk); #1;
        chk("bub_idle", 128'(busy), 128'(0));

        // start pulses in RUN and DONE are dropped; start after DONE is taken
        @(negedge clk);
        start = 1'b1; use_init = 1'b0; k_len = 4'd2; vec_valid = 1'b0;
        vec_a = 32'h01010101; vec_b = 32'h01010101;
        @(posedge clk); #1;
        start = 1'b1; k_len = 4'd5; use_init = 1'b1; init_tile = {16{8'hFF}};
        @(posedge clk); #1;
        start = 1'b0;
        chk("ign_run_tile", tile_o, 128'h0);
        chk("ign_run_busy", 128'(busy), 128'(1));
        vec_valid = 1'b1;
        @(posedge clk); #1;
        chk("ign_cnt_early", 128'(done), 128'(0));
        @(posedge clk); #1;
        chk("ign_cnt_done", 128'(done), 128'(1));
        chk("ign_tile", tile_o, {16{8'h02}});
        vec_valid = 1'b0; start = 1'b1; k_len = 4'd1; use_init = 1'b1;
        init_tile = {16{8'hFF}};
        @(posedge clk); #1;
        chk("ign_done_busy", 128'(busy), 128'(0));
        chk("ign_done_tile", tile_o, {16{8'h02}});
        @(posedge clk); #1;
        chk("next_start_busy", 128'(busy), 128'(1));
        chk("next_start_ready", 128'(vec_ready), 128'(1));
        chk("next_start_tile", tile_o, {16{8'hFF}});
        start = 1'b0; vec_valid = 1'b1;
        @(posedge clk); #1;
        chk("next_start_done", 128'(done), 128'(1));
        chk("next_start_wrap", tile_o, 128'h0);
        vec_valid = 1'b0;
        @(posedge clk); #1;

        // reset in the middle of a run discards the partial tile
        @(negedge clk);
        start = 1'b1; use_init = 1'b0; k_len = 4'd4; vec_valid = 1'b0;
        vec_a = 32'h01010101; vec_b = 32'h01010101;
        @(posedge clk); #1;
        start = 1'b0; vec_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_partial", tile_o, {16{8'h02}});
        vec_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_busy", 128'(busy), 128'(0));
        chk("mid_ready", 128'(vec_ready), 128'(0));
        chk("mid_tile", tile_o, 128'h0);
        chk("mid_done", 128'(done), 128'(0));
        for (int w = 0; w < 4; w++) begin
            @(posedge clk); #1;
            chk("mid_no_done", 128'(done | busy), 128'(0));
        end
        do_seq(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
